// File: rtl/reaction_timer_if.sv
// Handshake bundle between the reaction timer and its environment:
// the tick, random and player inputs, plus the lamp and trial-result outputs.
interface reaction_timer_if;
    logic        tick;
    logic [7:0]  rnd;
    logic        start;
    logic        resp;
    logic        led;
    logic        busy;
    logic        done;
    logic        early;
    logic        timeout;
    logic [11:0] rt_ms;

    modport master (
        output tick, rnd, start, resp,
        input  led, busy, done, early, timeout, rt_ms
    );

    modport slave (
        input  tick, rnd, start, resp,
        output led, busy, done, early, timeout, rt_ms
    );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time trial controller: random stimulus delay, lamp, then counts
// ticks until the player responds, with false-start and timeout detection.
//
// state  | meaning
// IDLE   | no trial since reset; waiting for start
// WAIT   | random delay running down; lamp off
// GO     | lamp on; counting reaction ticks
// RESULT | trial finished; results held until next start
module reaction_timer #(
    parameter int MIN_DLY_MS = 1000,
    parameter int MAX_RT_MS  = 1999
) (
    input  logic              clk,
    input  logic              ar,
    reaction_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        GO     = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [11:0] MIN_DLY  = 12'(MIN_DLY_MS);
    localparam logic [11:0] MAX_RT   = 12'(MAX_RT_MS);
    localparam logic [11:0] LAST_INC = 12'(MAX_RT_MS - 1);

    state_t      state;
    logic [11:0] dly_cnt;
    logic [11:0] rt_q;
    logic        led_q;
    logic        busy_q;
    logic        done_q;
    logic        early_q;
    logic        timeout_q;

    always_ff @(posedge clk) begin
        if (ar) begin
            state     <= IDLE;
            dly_cnt   <= '0;
            rt_q      <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE, RESULT: begin
                    if (bus.start) begin
                        state     <= WAIT;
                        dly_cnt   <= MIN_DLY + {1'b0, bus.rnd, 3'b000};
                        rt_q      <= '0;
                        early_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        led_q     <= 1'b0;
                    end
                end

                WAIT: begin
                    // A response on the expiring tick is still a false start.
                    if (bus.resp) begin
                        state   <= RESULT;
                        early_q <= 1'b1;
                        rt_q    <= '0;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bus.tick) begin
                        if (dly_cnt <= 12'd1) begin
                            dly_cnt <= '0;
                            state   <= GO;
                            led_q   <= 1'b1;
                            rt_q    <= '0;
                        end else begin
                            dly_cnt <= dly_cnt - 12'd1;
                        end
                    end
                end

                GO: begin
                    if (bus.resp) begin
                        state  <= RESULT;
                        led_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (bus.tick) begin
                        // Saturate at the timeout count rather than wrapping.
                        if (rt_q >= LAST_INC) begin
                            rt_q      <= MAX_RT;
                            timeout_q <= 1'b1;
                            state     <= RESULT;
                            led_q     <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            rt_q <= rt_q + 12'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.led     = led_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.early   = early_q;
    assign bus.timeout = timeout_q;
    assign bus.rt_ms   = rt_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: a short per-cycle vector table followed
// by long tick sequences for delay expiry, reaction counting and timeout.
module tb_reaction_timer;

    logic clk;
    logic ar;

    reaction_timer_if bus ();

    reaction_timer #(
        .MIN_DLY_MS (1000),
        .MAX_RT_MS  (1999)
    ) dut (
        .clk (clk),
        .ar  (ar),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ar;
        logic        tick;
        logic        start;
        logic        resp;
        logic [7:0]  rnd;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl [13];

    int nvec;
    int nerr;
    int bad;

    wire [16:0] obs = {bus.led, bus.busy, bus.done, bus.early, bus.timeout, bus.rt_ms};

    function automatic logic [16:0] o(input logic led, input logic busy, input logic done,
                                      input logic early, input logic tmo, input int rt);
        return {led, busy, done, early, tmo, 12'(rt)};
    endfunction

    task automatic step(input logic t, input logic s, input logic r,
                        input logic [7:0] rv, input logic a);
        @(negedge clk);
        bus.tick  = t;
        bus.start = s;
        bus.resp  = r;
        bus.rnd   = rv;
        ar        = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [16:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got led=%b busy=%b done=%b early=%b timeout=%b rt_ms=%0d, want led=%b busy=%b done=%b early=%b timeout=%b rt_ms=%0d",
                     name, obs[16], obs[15], obs[14], obs[13], obs[12], obs[11:0],
                     exp[16], exp[15], exp[14], exp[13], exp[12], exp[11:0]);
        end
    endtask

    task automatic check_flag(input string name, input int flag);
        nvec++;
        if (flag != 0) begin
            nerr++;
            $display("FAIL %s: %0d cycles with unexpected led/busy, want 0", name, flag);
        end
    endtask

    // Apply n tick cycles; count cycles where led or busy differ from the given levels.
    task automatic ticks(input int n, input logic want_led, input logic want_busy,
                         output int nbad);
        nbad = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            if (bus.led !== want_led || bus.busy !== want_busy) nbad++;
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.resp  = 1'b0;
        bus.rnd   = 8'h00;
        ar        = 1'b1;

        //             ar    tick  start resp  rnd     expected
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, o(0,0,0,0,0,0)};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, o(0,0,0,0,0,0)};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, o(0,1,0,0,0,0)};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, o(0,1,0,0,0,0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, o(0,0,1,1,0,0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, o(0,0,1,1,0,0)};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, o(0,0,1,1,0,0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h05, o(0,1,0,0,0,0)};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, o(0,1,0,0,0,0)};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, o(0,0,0,0,0,0)};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, o(0,1,0,0,0,0)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, o(0,0,1,1,0,0)};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, o(0,0,0,0,0,0)};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].tick, tbl[i].start, tbl[i].resp, tbl[i].rnd, tbl[i].ar);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Minimum delay, reaction of 250, then hold in RESULT
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        ticks(999, 1'b0, 1'b1, bad);
        check_flag("min_dly_wait", bad);
        check("min_dly_999", o(0,1,0,0,0,0));
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("min_dly_1000", o(1,1,0,0,0,0));
        ticks(250, 1'b1, 1'b1, bad);
        check("go_250", o(1,1,0,0,0,250));
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("resp_250", o(0,0,1,0,0,250));
        ticks(100, 1'b0, 1'b0, bad);
        check("hold_250", o(0,0,1,0,0,250));

        // Maximum delay with rnd changed after start, then timeout
        step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        ticks(3039, 1'b0, 1'b1, bad);
        check_flag("max_dly_wait", bad);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("max_dly_3040", o(1,1,0,0,0,0));
        ticks(1998, 1'b1, 1'b1, bad);
        check("go_1998", o(1,1,0,0,0,1998));
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("timeout", o(0,0,1,0,1,1999));
        ticks(5, 1'b0, 1'b0, bad);
        check("timeout_hold", o(0,0,1,0,1,1999));

        // False start after 10 ticks
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("restart_clears", o(0,1,0,0,0,0));
        ticks(10, 1'b0, 1'b1, bad);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("early_10", o(0,0,1,1,0,0));

        // False start coincident with the expiring tick
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        ticks(999, 1'b0, 1'b1, bad);
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check("early_coincident", o(0,0,1,1,0,0));
        ticks(3, 1'b0, 1'b0, bad);
        check_flag("early_no_led", bad);

        // Response coincident with tick at rt_ms=41
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        ticks(1000, 1'b0, 1'b1, bad);
        ticks(41, 1'b1, 1'b1, bad);
        check("go_41", o(1,1,0,0,0,41));
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check("resp_tick_41", o(0,0,1,0,0,41));

        // Reset mid-GO, then start in WAIT must not reload the delay
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        ticks(1000, 1'b0, 1'b1, bad);
        ticks(500, 1'b1, 1'b1, bad);
        check("go_500", o(1,1,0,0,0,500));
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
        check("reset_in_go", o(0,0,0,0,0,0));
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("start_after_reset", o(0,1,0,0,0,0));
        ticks(500, 1'b0, 1'b1, bad);
        step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        check("start_in_wait", o(0,1,0,0,0,0));
        ticks(499, 1'b0, 1'b1, bad);
        check_flag("no_reload_wait", bad);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("no_reload_go", o(1,1,0,0,0,0));
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check("start_in_go", o(1,1,0,0,0,1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
